// File: rtl/screen_frame_arbiter_pkg.sv
// Shared definitions for the screen frame arbiter.
// Holds the FSM state encoding, the blank picture constant and a helper
// that sizes counters so a counter reaching max_val never overflows.
package screen_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    SCR_IDLE = 2'd0,
    SCR_SHOW = 2'd1,
    SCR_GAP  = 2'd2
  } scr_state_e;

  localparam logic [63:0] BLANK_FRAME = 64'h0;

  // Bits needed to hold 0..max_val, never less than one bit so that
  // degenerate parameter values (max_val of 0 or 1) still give a legal vector.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/screen_frame_arbiter_if.sv
// Bundle between the picture sources and the screen frame arbiter.
// master modport: the source side (drives requests, pictures, blink enables).
// slave modport : the arbiter (drives grant, busy and the digi_screen planes).
//   req        NUM_REQ      level request per source
//   frame_r    NUM_REQ*64   red pictures, source i at [64*i +: 64]
//   frame_g    NUM_REQ*64   green pictures, same packing
//   blink_en   NUM_REQ      blink enable per source
//   grant      NUM_REQ      one-hot current owner, zero when none
//   busy       1            high while a source is shown or the gap runs
//   PICTURE_R  64           red plane for digi_screen
//   PICTURE_G  64           green plane for digi_screen
interface screen_frame_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*64-1:0] frame_r;
  logic [NUM_REQ*64-1:0] frame_g;
  logic [NUM_REQ-1:0]    blink_en;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic [63:0]           PICTURE_R;
  logic [63:0]           PICTURE_G;

  modport master (
    output req, frame_r, frame_g, blink_en,
    input  grant, busy, PICTURE_R, PICTURE_G
  );

  modport slave (
    input  req, frame_r, frame_g, blink_en,
    output grant, busy, PICTURE_R, PICTURE_G
  );

endinterface

// File: rtl/screen_frame_arbiter_fixed_prio_enc.sv
// Fixed-priority encoder, index 0 highest.
//   req     in   N       request vector
//   onehot  out  N       lowest set bit of req, zero when none
//   idx     out  IDX_W   index of that bit, zero when none
//   any     out  1       at least one request present
// The arbiter also compares idx against the current owner to detect a
// waiting higher-priority source.
module fixed_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk from the lowest priority upwards so the last hit (lowest index) wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/screen_frame_arbiter.sv
// Shares the 8x8 bicolour digi_screen driver between NUM_REQ picture sources.
// Fixed priority (index 0 highest), a minimum display time before a
// higher-priority source may preempt, a blank gap between owners and
// per-source blinking. All outputs are registered.
//   clk   in  system clock shared with digi_screen
//   rst   in  synchronous active-high reset
//   bus   slave modport of screen_frame_arbiter_if (req/frames/blink_en in,
//         grant/busy/PICTURE_R/PICTURE_G out)
module screen_frame_arbiter
  import screen_frame_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_TICKS  = 1000,
  parameter int GAP_TICKS   = 100,
  parameter int BLINK_TICKS = 500
) (
  input logic                   clk,
  input logic                   rst,
  screen_frame_arbiter_if.slave bus
);

  localparam int IDX_W   = cnt_width(NUM_REQ - 1);
  localparam int HOLD_W  = cnt_width(HOLD_TICKS);
  localparam int GAP_W   = cnt_width(GAP_TICKS - 1);
  localparam int BLINK_W = cnt_width(BLINK_TICKS - 1);

  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_TICKS);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  scr_state_e          state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic                phase_q, phase_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [63:0]         pic_r_q, pic_r_d;
  logic [63:0]         pic_g_q, pic_g_d;

  logic [NUM_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  logic                load_winner;

  fixed_prio_enc #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req    (bus.req),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  function automatic logic [63:0] pick_frame(input logic [NUM_REQ*64-1:0] frames,
                                             input logic [IDX_W-1:0]      sel);
    logic [63:0] f;
    f = BLANK_FRAME;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) f = frames[64*i +: 64];
    end
    return f;
  endfunction

  // Next-state and next-output logic. Pictures default to blank so only the
  // SHOW hold path and a fresh grant ever put a source frame on the screen.
  // The blink mask uses the phase as it will be after this edge so that the
  // first visible half-period is exactly BLINK_TICKS cycles long.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    blink_d     = blink_q;
    phase_d     = phase_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    pic_r_d     = BLANK_FRAME;
    pic_g_d     = BLANK_FRAME;
    load_winner = 1'b0;

    case (state_q)
      SCR_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (win_any) load_winner = 1'b1;
      end

      SCR_SHOW: begin
        // Dropping the request always ends the turn, even before the hold
        // time and even if a higher source asks in the same cycle.
        if (!bus.req[owner_q] || (win_idx < owner_q && hold_q == HOLD_MAX)) begin
          state_d = SCR_GAP;
          gap_d   = '0;
          grant_d = '0;
          busy_d  = 1'b1;
        end else begin
          hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
          end
          if (!(bus.blink_en[owner_q] && phase_d)) begin
            pic_r_d = pick_frame(bus.frame_r, owner_q);
            pic_g_d = pick_frame(bus.frame_g, owner_q);
          end
        end
      end

      SCR_GAP: begin
        grant_d = '0;
        busy_d  = 1'b1;
        if (gap_q == GAP_LAST) begin
          if (win_any) begin
            load_winner = 1'b1;
          end else begin
            state_d = SCR_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = SCR_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    // A new owner starts with fresh hold/blink timing and is shown at once.
    if (load_winner) begin
      state_d = SCR_SHOW;
      owner_d = win_idx;
      grant_d = win_onehot;
      busy_d  = 1'b1;
      hold_d  = '0;
      blink_d = '0;
      phase_d = 1'b0;
      pic_r_d = pick_frame(bus.frame_r, win_idx);
      pic_g_d = pick_frame(bus.frame_g, win_idx);
    end
  end

  // State, counters and the registered outputs all update together; reset
  // wins over everything and blanks the screen on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCR_IDLE;
      owner_q <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      pic_r_q <= BLANK_FRAME;
      pic_g_q <= BLANK_FRAME;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      pic_r_q <= pic_r_d;
      pic_g_q <= pic_g_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.PICTURE_R = pic_r_q;
  assign bus.PICTURE_G = pic_g_q;

endmodule
